// File: rtl/piton_dcr_target_if.sv
// DCR write channel between the Piton DCR buffer and the Vortex responder.
// The buffer pops its entry on (valid && !busy).
interface piton_dcr_target_if #(
    parameter int AW = 8,
    parameter int DW = 32
);
    logic          dcr_wr_valid;
    logic [AW-1:0] dcr_wr_addr;
    logic [DW-1:0] dcr_wr_data;
    logic          dcr_busy;

    modport master (
        output dcr_wr_valid,
        output dcr_wr_addr,
        output dcr_wr_data,
        input  dcr_busy
    );

    modport slave (
        input  dcr_wr_valid,
        input  dcr_wr_addr,
        input  dcr_wr_data,
        output dcr_busy
    );
endinterface

// File: rtl/piton_dcr_target.sv
// Vortex-side DCR write responder: register file, readback port,
// sticky unmapped-address capture and launch pulse.
module piton_dcr_target #(
    parameter int                           VX_DCR_ADDR_WIDTH = 8,
    parameter int                           VX_DCR_DATA_WIDTH = 32,
    parameter logic [VX_DCR_ADDR_WIDTH-1:0] DCR_BASE          = 8'h01,
    parameter int                           NUM_REGS          = 8,
    parameter int                           COMMIT_LAT        = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    piton_dcr_target_if.slave            dcr,
    input  logic                         rd_valid,
    input  logic [$clog2(NUM_REGS)-1:0]  rd_idx,
    output logic                         rd_resp_valid,
    output logic [VX_DCR_DATA_WIDTH-1:0] rd_data,
    output logic                         cfg_launch,
    output logic                         err_unmapped,
    output logic [VX_DCR_ADDR_WIDTH-1:0] err_addr,
    input  logic                         err_clr,
    output logic [15:0]                  wr_count
);
    localparam int AW = VX_DCR_ADDR_WIDTH;
    localparam int DW = VX_DCR_DATA_WIDTH;
    localparam int IW = $clog2(NUM_REGS);

    typedef enum logic {IDLE, COMMIT} state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic [DW-1:0] regs_q [NUM_REGS];
    logic [DW-1:0] regs_d [NUM_REGS];
    logic          rd_resp_valid_q, rd_resp_valid_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          launch_q, launch_d;
    logic          err_q, err_d;
    logic [AW-1:0] err_addr_q, err_addr_d;
    logic [15:0]   wr_count_q, wr_count_d;

    // One extra bit keeps addresses below DCR_BASE from wrapping into range
    logic [AW:0]   off;
    logic          mapped;
    logic [IW-1:0] idx;

    assign off    = {1'b0, addr_q} - {1'b0, DCR_BASE};
    assign mapped = !off[AW] && (off < (AW+1)'(NUM_REGS));
    assign idx    = off[IW-1:0];

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        busy_d          = busy_q;
        addr_d          = addr_q;
        data_d          = data_q;
        regs_d          = regs_q;
        rd_resp_valid_d = rd_valid;
        rd_data_d       = rd_data_q;
        launch_d        = 1'b0;
        err_d           = err_q;
        err_addr_d      = err_addr_q;
        wr_count_d      = wr_count_q;

        if (rd_valid) begin
            rd_data_d = regs_q[rd_idx];
        end

        if (err_clr) begin
            err_d      = 1'b0;
            err_addr_d = '0;
        end

        unique case (state_q)
            IDLE: begin
                if (dcr.dcr_wr_valid && !busy_q) begin
                    state_d = COMMIT;
                    busy_d  = 1'b1;
                    cnt_d   = 4'(COMMIT_LAT);
                    addr_d  = dcr.dcr_wr_addr;
                    data_d  = dcr.dcr_wr_data;
                    if (wr_count_q != 16'hFFFF) begin
                        wr_count_d = wr_count_q + 16'd1;
                    end
                end
            end
            COMMIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    if (mapped) begin
                        regs_d[idx] = data_q;
                        launch_d    = (idx == IW'(NUM_REGS-1));
                    end else begin
                        err_d = 1'b1;
                        // First error since the last clear is kept
                        if (!err_q || err_clr) begin
                            err_addr_d = addr_q;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            busy_q          <= 1'b0;
            addr_q          <= '0;
            data_q          <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            rd_resp_valid_q <= 1'b0;
            rd_data_q       <= '0;
            launch_q        <= 1'b0;
            err_q           <= 1'b0;
            err_addr_q      <= '0;
            wr_count_q      <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            busy_q          <= busy_d;
            addr_q          <= addr_d;
            data_q          <= data_d;
            regs_q          <= regs_d;
            rd_resp_valid_q <= rd_resp_valid_d;
            rd_data_q       <= rd_data_d;
            launch_q        <= launch_d;
            err_q           <= err_d;
            err_addr_q      <= err_addr_d;
            wr_count_q      <= wr_count_d;
        end
    end

    assign dcr.dcr_busy  = busy_q;
    assign rd_resp_valid = rd_resp_valid_q;
    assign rd_data       = rd_data_q;
    assign cfg_launch    = launch_q;
    assign err_unmapped  = err_q;
    assign err_addr      = err_addr_q;
    assign wr_count      = wr_count_q;
endmodule

// File: tb/tb_piton_dcr_target.sv
// Bench for piton_dcr_target: write vector table, readback scoreboard
// and hand-written reset/error/saturation sequences.
module tb_piton_dcr_target;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_valid = 1'b0;
    logic [2:0]  rd_idx = '0;
    logic        rd_resp_valid;
    logic [31:0] rd_data;
    logic        cfg_launch;
    logic        err_unmapped;
    logic [7:0]  err_addr;
    logic        err_clr = 1'b0;
    logic [15:0] wr_count;

    int n_tests = 0;
    int n_fail  = 0;
    int launch_cnt = 0;
    logic [31:0] exp_q [$];

    piton_dcr_target_if #(.AW(8), .DW(32)) dcr_if ();

    piton_dcr_target #(
        .VX_DCR_ADDR_WIDTH (8),
        .VX_DCR_DATA_WIDTH (32),
        .DCR_BASE          (8'h01),
        .NUM_REGS          (8),
        .COMMIT_LAT        (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .dcr           (dcr_if.slave),
        .rd_valid      (rd_valid),
        .rd_idx        (rd_idx),
        .rd_resp_valid (rd_resp_valid),
        .rd_data       (rd_data),
        .cfg_launch    (cfg_launch),
        .err_unmapped  (err_unmapped),
        .err_addr      (err_addr),
        .err_clr       (err_clr),
        .wr_count      (wr_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Readback scoreboard
    always @(negedge clk) begin
        if (cfg_launch) launch_cnt++;
        if (rd_resp_valid) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_unexpected: got %h expected no response",
                         rd_data);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    n_fail++;
                    $display("FAIL rd_data: got %h expected %h", rd_data, e);
                end
            end
        end
    end

    task automatic rd(input logic [2:0] idx, input logic [31:0] exp);
        rd_valid = 1'b1;
        rd_idx   = idx;
        exp_q.push_back(exp);
        @(negedge clk);
        rd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 50 && dcr_if.dcr_busy; k++) @(negedge clk);
        chk("wait_idle", 32'(dcr_if.dcr_busy), 32'd0);
    endtask

    // Full write; optional err_clr and read issued in the commit cycle
    task automatic do_write(input logic [7:0] a, input logic [31:0] d,
                            input logic clr, input logic crd,
                            input logic [2:0] cidx, input logic [31:0] cexp);
        wait_idle();
        dcr_if.dcr_wr_valid = 1'b1;
        dcr_if.dcr_wr_addr  = a;
        dcr_if.dcr_wr_data  = d;
        @(negedge clk);
        dcr_if.dcr_wr_valid = 1'b0;
        chk("busy_t1", 32'(dcr_if.dcr_busy), 32'd1);
        @(negedge clk);
        chk("busy_t2", 32'(dcr_if.dcr_busy), 32'd1);
        err_clr = clr;
        if (crd) begin
            rd_valid = 1'b1;
            rd_idx   = cidx;
            exp_q.push_back(cexp);
        end
        @(negedge clk);
        err_clr  = 1'b0;
        rd_valid = 1'b0;
        chk("busy_t3", 32'(dcr_if.dcr_busy), 32'd0);
    endtask

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        logic        launch;
        logic        err;
        logic [7:0]  eaddr;
    } wvec_t;

    wvec_t tbl [12];

    initial begin
        dcr_if.dcr_wr_valid = 1'b0;
        dcr_if.dcr_wr_addr  = '0;
        dcr_if.dcr_wr_data  = '0;

        for (int i = 0; i < 8; i++) begin
            tbl[i] = '{8'(i + 1), 32'(i + 1), (i == 7), 1'b0, 8'h00};
        end
        tbl[8]  = '{8'h00, 32'hAAAA_0000, 1'b0, 1'b1, 8'h00};
        tbl[9]  = '{8'h20, 32'hAAAA_0020, 1'b0, 1'b1, 8'h00};
        tbl[10] = '{8'h09, 32'hAAAA_0009, 1'b0, 1'b1, 8'h00};
        tbl[11] = '{8'hFF, 32'hAAAA_00FF, 1'b0, 1'b1, 8'h00};

        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(dcr_if.dcr_busy), 32'd0);
        chk("rst_wr_count", 32'(wr_count), 32'd0);
        chk("rst_err", 32'(err_unmapped), 32'd0);
        chk("rst_err_addr", 32'(err_addr), 32'd0);
        chk("rst_launch", 32'(cfg_launch), 32'd0);
        chk("rst_rd_valid", 32'(rd_resp_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single mapped write and readback
        do_write(8'h01, 32'hDEADBEEF, 1'b0, 1'b0, 3'd0, 32'd0);
        rd(3'd0, 32'hDEADBEEF);
        chk("wr_count_1", 32'(wr_count), 32'd1);

        // Read of the committing entry sees the old value
        do_write(8'h03, 32'h5, 1'b0, 1'b1, 3'd2, 32'h0);
        rd(3'd2, 32'h5);
        chk("wr_count_2", 32'(wr_count), 32'd2);

        // Held valid: one accept per commit window
        wait_idle();
        dcr_if.dcr_wr_valid = 1'b1;
        dcr_if.dcr_wr_addr  = tbl[0].addr;
        dcr_if.dcr_wr_data  = tbl[0].data;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("tbl_busy_t1", 32'(dcr_if.dcr_busy), 32'd1);
            if (i < 11) begin
                dcr_if.dcr_wr_addr = tbl[i+1].addr;
                dcr_if.dcr_wr_data = tbl[i+1].data;
            end else begin
                dcr_if.dcr_wr_valid = 1'b0;
            end
            @(negedge clk);
            chk("tbl_busy_t2", 32'(dcr_if.dcr_busy), 32'd1);
            chk("tbl_launch_t2", 32'(cfg_launch), 32'd0);
            @(negedge clk);
            chk("tbl_busy_t3", 32'(dcr_if.dcr_busy), 32'd0);
            chk("tbl_launch_t3", 32'(cfg_launch), 32'(tbl[i].launch));
            chk("tbl_err", 32'(err_unmapped), 32'(tbl[i].err));
            chk("tbl_err_addr", 32'(err_addr), 32'(tbl[i].eaddr));
        end
        chk("wr_count_tbl", 32'(wr_count), 32'd14);
        chk("launch_once", 32'(launch_cnt), 32'd1);
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), 32'(i + 1));
        end
        @(negedge clk);
        chk("rd_idle_valid", 32'(rd_resp_valid), 32'd0);
        chk("rd_idle_hold", rd_data, 32'd8);

        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("clr_err", 32'(err_unmapped), 32'd0);
        chk("clr_err_addr", 32'(err_addr), 32'd0);

        // Clear and new unmapped commit together: set wins
        do_write(8'h09, 32'h1, 1'b0, 1'b0, 3'd0, 32'd0);
        chk("err_09", 32'(err_unmapped), 32'd1);
        chk("err_addr_09", 32'(err_addr), 32'h09);
        do_write(8'h30, 32'h2, 1'b1, 1'b0, 3'd0, 32'd0);
        chk("err_set_wins", 32'(err_unmapped), 32'd1);
        chk("err_addr_30", 32'(err_addr), 32'h30);

        // Reset in the middle of a launch-DCR commit
        wait_idle();
        dcr_if.dcr_wr_valid = 1'b1;
        dcr_if.dcr_wr_addr  = 8'h08;
        dcr_if.dcr_wr_data  = 32'h77;
        @(negedge clk);
        dcr_if.dcr_wr_valid = 1'b0;
        chk("abort_busy_pre", 32'(dcr_if.dcr_busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(dcr_if.dcr_busy), 32'd0);
        chk("abort_wr_count", 32'(wr_count), 32'd0);
        chk("abort_err", 32'(err_unmapped), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_busy_post", 32'(dcr_if.dcr_busy), 32'd0);
        chk("abort_no_launch", 32'(launch_cnt), 32'd1);
        rd(3'd7, 32'h0);

        // Saturation near the top of the counter
        force dut.wr_count_q = 16'hFFFD;
        @(negedge clk);
        release dut.wr_count_q;
        @(negedge clk);
        chk("sat_preload", 32'(wr_count), 32'hFFFD);
        do_write(8'h01, 32'h11, 1'b0, 1'b0, 3'd0, 32'd0);
        chk("sat_fffe", 32'(wr_count), 32'hFFFE);
        do_write(8'h02, 32'h22, 1'b0, 1'b0, 3'd0, 32'd0);
        chk("sat_ffff", 32'(wr_count), 32'hFFFF);
        do_write(8'h00, 32'h33, 1'b0, 1'b0, 3'd0, 32'd0);
        chk("sat_hold", 32'(wr_count), 32'hFFFF);

        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/piton_dcr_target.md
Name: piton_dcr_target

Overview:
Vortex-side responder for the DCR write interface driven by the Piton DCR buffer. It accepts one DCR write per handshake, holds dcr_busy while the write commits, and stores mapped writes in a local register file. It exposes a registered readback port for debug/MMIO, sticky error capture for unmapped addresses, and a one-cycle launch pulse when the last register (launch DCR) commits. It sits between the DCR buffer output and the Vortex startup/config logic.

Parameters:
VX_DCR_ADDR_WIDTH, 8, DCR address width.
VX_DCR_DATA_WIDTH, 32, DCR data width.
DCR_BASE, 8'h01, first mapped DCR address.
NUM_REGS, 8, number of mapped registers; power of 2, 2..16; the top index is the launch DCR.
COMMIT_LAT, 2, busy cycles per write; legal range 1..15.

Ports:
clk  in  1  clock.
rst  in  1  reset; asynchronous, active-high.
dcr_wr_valid  in  1  write request from the DCR buffer.
dcr_wr_addr  in  VX_DCR_ADDR_WIDTH  write address.
dcr_wr_data  in  VX_DCR_DATA_WIDTH  write data.
dcr_busy  out  1  responder busy; a write is accepted only when it is low.
rd_valid  in  1  readback request.
rd_idx  in  $clog2(NUM_REGS)  register index to read.
rd_resp_valid  out  1  readback data valid.
rd_data  out  VX_DCR_DATA_WIDTH  readback data.
cfg_launch  out  1  one-cycle pulse when a launch-DCR write commits.
err_unmapped  out  1  sticky flag for unmapped-address writes.
err_addr  out  VX_DCR_ADDR_WIDTH  address of the first unmapped write since the last clear.
err_clr  in  1  clears err_unmapped and err_addr.
wr_count  out  16  number of accepted writes; saturates at 16'hFFFF.

Behaviour:
- Reset: all outputs 0, register file 0, FSM in IDLE. Reset mid-commit aborts the pending write: no register update and no cfg_launch.
- dcr_busy is driven directly from a flop; there is no combinational path from dcr_wr_valid to dcr_busy. This is required because the upstream buffer pops its entry on (valid && !busy) in the same cycle.
- Accept: in cycle T, dcr_wr_valid=1 and dcr_busy=0. Address and data are captured into holding registers at the T edge, wr_count increments, FSM goes IDLE->COMMIT, and the down-counter loads COMMIT_LAT.
- COMMIT: dcr_busy=1 for cycles T+1..T+COMMIT_LAT. dcr_wr_valid is ignored during COMMIT.
- At the end of cycle T+COMMIT_LAT:
  - Mapped write: register file entry (addr-DCR_BASE) is updated; the new value is visible from T+COMMIT_LAT+1.
  - Unmapped write: no register update.
  - FSM returns to IDLE; dcr_busy=0 in T+COMMIT_LAT+1.
- Throughput: at most one write per COMMIT_LAT+1 cycles. Back-to-back valid is accepted on the first cycle busy is low.
- Mapped range: DCR_BASE <= addr <= DCR_BASE+NUM_REGS-1. Address arithmetic is unsigned at VX_DCR_ADDR_WIDTH+1 bits, so there is no wrap at the top of the address space.
- cfg_launch: 1 in cycle T+COMMIT_LAT+1 only, and only for a committed write to index NUM_REGS-1.
- Unmapped write:
  - At commit, err_unmapped is set.
  - err_addr is loaded only if err_unmapped was 0 (first-error capture).
  - The write takes the same busy timing as a mapped write.
- err_clr and a new unmapped commit in the same cycle: set wins, and err_addr takes the new address.
- Readback:
  - rd_valid in cycle R gives rd_resp_valid=1 and rd_data=regfile[rd_idx] in cycle R+1, sampled at the R edge.
  - A read of an entry committing in the same cycle returns the old value.
  - rd_resp_valid=0 when rd_valid was 0; rd_data then holds its last value.
  - Reads are accepted in any FSM state.
- wr_count counts all accepted writes, mapped and unmapped, and holds at 16'hFFFF.
- FSM: IDLE (busy=0) -> COMMIT on accept. COMMIT (busy=1) decrements the counter and returns to IDLE when the counter reaches 1. No other states.

Test Plan:
1. Reset, then write addr 8'h01 data 32'hDEADBEEF at T -> dcr_busy=1 at T+1 and T+2, 0 at T+3. Read idx 0 at T+3 -> rd_data=32'hDEADBEEF, rd_resp_valid=1 at T+4. wr_count=1.
2. Hold dcr_wr_valid=1 continuously with addrs 8'h01..8'h08 and data 1..8 -> one accept every 3 cycles; all 8 entries read back 1..8. cfg_launch pulses exactly once, 3 cycles after the 8'h08 accept.
3. Write unmapped 8'h00, then 8'h20 -> err_unmapped=1, err_addr=8'h00 (first kept), busy timing unchanged, register file unchanged. Then pulse err_clr -> both cleared.
4. Assert err_clr in the same cycle an unmapped 8'h30 write commits -> err_unmapped=1, err_addr=8'h30.
5. Write 8'h03 data 32'h5, then read idx 2 in the commit cycle -> old value 0. Read again one cycle later -> 32'h5.
6. Assert rst during COMMIT of a launch-DCR write -> dcr_busy=0, no cfg_launch, entry 7 = 0. Then force 65536 writes -> wr_count saturates at 16'hFFFF.
